tm_feedback_ctrl: RTL and testbench
===================================

# tm_feedback_ctrl

Per-sample feedback controller for one Tsetlin-machine class. It consumes the signed class vote sum that the class block produces and the training label. It decides, with Tsetlin resource-allocation probability, whether to broadcast a one-cycle `positive_feedback` (Type I) or `negative_feedback` (Type II) pulse back to that class's clauses. It also tracks prediction errors for training monitoring.

## Interface
Parameters:
- `VOTE_W`, 3: width of the signed vote input, two's complement.
- `T`, 2: vote clamp threshold; legal range 1..127.
- `LFSR_SEED`, 8'hA5: LFSR reset value. A value of 0 is replaced by 8'h01.
- `ERR_W`, 16: width of the error counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `in_valid`  in  1  a sample (`votes`, `y`) is presented.
- `in_ready`  out  1  controller can accept a sample.
- `votes`  in  VOTE_W  signed class vote sum for the current input.
- `y`  in  1  target label: 1 means the sample belongs to the class, 0 means it does not.
- `positive_feedback`  out  1  one-cycle Type I pulse to the clauses.
- `negative_feedback`  out  1  one-cycle Type II pulse to the clauses.
- `done`  out  1  one-cycle pulse marking that the sample's decision is complete.
- `predicted`  out  1  registered class decision for the last sample: 1 if votes ≥ 0.
- `err_cnt`  out  ERR_W  saturating count of samples where `predicted` ≠ `y`.

## Operation
- FSM states: IDLE → CLAMP → DRAW → APPLY → IDLE. No other transitions occur.
- IDLE:
  - `in_ready` = 1; it is high only in this state.
  - On `in_valid && in_ready`, capture `votes` and `y`, then go to CLAMP.
  - `in_valid` in any other state is ignored.
- CLAMP:
  - `vc` = clamp(signed votes, −T, +T).
  - `num` = T − vc if y=1, or T + vc if y=0. `num` ranges 0..2T and is held in 9 bits unsigned.
  - `predicted` ← (votes ≥ 0), using the unclamped value.
- DRAW:
  - Step the LFSR once and take the new value as `rnd` (0..255).
  - `accept` = (rnd × 2T) < (num × 256). Compute at ≥17-bit unsigned width; truncation is not allowed.
  - Consequences: num=0 never accepts; num=2T always accepts.
- APPLY:
  - Pulse `positive_feedback` = accept & y.
  - Pulse `negative_feedback` = accept & ~y.
  - Pulse `done`.
  - If `predicted` ≠ `y`, increment `err_cnt`. It saturates at all-ones and never wraps.
- LFSR:
  - 8-bit Galois type, shift right, feedback mask 8'hB8 (x^8+x^6+x^5+x^4+1).
  - Advances only in DRAW, so the random sequence is a deterministic function of the number of samples processed.
- The two feedback outputs are never high in the same cycle.

## Timing
- Cycle 0 is the handshake cycle. The FSM is in CLAMP at cycle 1, DRAW at cycle 2, and APPLY at cycle 3.
  - Feedback and `done` pulses are visible during cycle 3.
  - `predicted` updates at the end of cycle 1.
  - `err_cnt` updates at the end of cycle 3.
- `in_ready` is high again at cycle 4. Maximum throughput is one sample per 4 cycles.
- All outputs are registered; there are no combinational input→output paths other than `in_ready`, which is decoded from state.
- Reset values:
  - state = IDLE, so `in_ready` = 1.
  - `positive_feedback` = `negative_feedback` = `done` = 0.
  - `predicted` = 0, `err_cnt` = 0.
  - LFSR = seed.
- Reset mid-sample: the in-flight sample is discarded with no pulse, and the LFSR is reseeded.
- `votes`/`y` changing after the handshake has no effect on the in-flight sample.

## Structure
- Shared package `tm_pkg`:
  - FSM state enum (IDLE, CLAMP, DRAW, APPLY).
  - LFSR mask constant 8'hB8.
  - Function `tm_clamp(v, t)` for reuse by other class controllers.
- Sub-module `tm_lfsr8`: ports clk, rst, step, seed, value. Reused by the planned clause-level state-update block.
- Top level: FSM, datapath registers, error counter. Target ~150–250 lines.

## Test plan
- Reset: assert `rst`=0 mid-sample at cycle 2. Required: all pulses stay 0, `in_ready`=1 one cycle after release, `err_cnt`=0, and the next draw reproduces the post-reset sequence.
- T=2, votes=+2, y=1 (num=0), repeated 50 times. Required: `positive_feedback` never pulses, `done` pulses every 4 cycles, `err_cnt` stays 0.
- T=2, votes=−2, y=1 (num=4). Required: `positive_feedback` pulses every sample at cycle 3, `predicted`=0, and `err_cnt` increments by 1 per sample.
- Clamp, T=2: votes=3'b100 (−4), y=0. Required: vc=−2, num=0, no `negative_feedback`, `predicted`=0, `err_cnt` unchanged.
- Statistics, T=2: votes=0, y=0 (num=2, p=0.5) over 1000 samples. Required: `negative_feedback` count matches a bit-exact LFSR reference model, and lies within 450..550.
- Back-pressure and saturation:
  - `in_valid` held high continuously: exactly one handshake per 4 cycles.
  - With ERR_W=4 and 20 mispredicted samples: `err_cnt` stops at 15.

Source files
------------

// File: rtl/tm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tm_pkg
// Purpose  : Shared types, constants and helpers for Tsetlin-machine
//            class feedback controllers.
// Revision : 1.0 - initial release
// ============================================================================
package tm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAMP = 2'd1,
        DRAW  = 2'd2,
        APPLY = 2'd3
    } tm_state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, Galois form, shifting right
    localparam logic [7:0] C_LFSR_MASK = 8'hB8;

    function automatic int tm_clamp(input int v, input int t);
        if (v > t) begin
            return t;
        end
        if (v < -t) begin
            return -t;
        end
        return v;
    endfunction

    function automatic logic [7:0] tm_lfsr_next(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? C_LFSR_MASK : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tm_lfsr8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tm_lfsr8
// Purpose  : 8-bit right-shifting Galois LFSR; advances once per step.
// Revision : 1.0 - initial release
// ============================================================================
module tm_lfsr8
    import tm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] w_seed;
    logic [7:0] r_value;

    // An all-zero state would lock the register up forever
    assign w_seed = (seed == 8'h00) ? 8'h01 : seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= w_seed;
        end else if (step) begin
            r_value <= tm_lfsr_next(r_value);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/tm_feedback_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tm_feedback_ctrl
// Purpose  : Per-sample Type I / Type II feedback decision for one class,
//            with prediction-error tracking.
// Revision : 1.0 - initial release
// ============================================================================
module tm_feedback_ctrl
    import tm_pkg::*;
#(
    parameter int         VOTE_W    = 3,
    parameter int         T         = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         ERR_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [VOTE_W-1:0] votes,
    input  logic                     y,
    output logic                     positive_feedback,
    output logic                     negative_feedback,
    output logic                     done,
    output logic                     predicted,
    output logic [ERR_W-1:0]         err_cnt
);

    localparam logic [7:0]  C_SEED   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [17:0] C_TWO_T  = 18'(2 * T);
    localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};

    tm_state_t                 r_state;
    logic signed [VOTE_W-1:0]  r_votes;
    logic                      r_y;
    logic [8:0]                r_num;
    logic                      r_pos;
    logic                      r_neg;
    logic                      r_done;
    logic                      r_pred;
    logic [ERR_W-1:0]          r_err;

    int                        w_vc;
    logic [8:0]                w_num;
    logic [7:0]                w_lfsr;
    logic [7:0]                w_rnd;
    logic [17:0]               w_lhs;
    logic [17:0]               w_rhs;
    logic                      w_accept;
    logic                      w_step;

    assign w_step = (r_state == DRAW);

    tm_lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (w_step),
        .seed  (C_SEED),
        .value (w_lfsr)
    );

    always_comb begin
        w_vc  = tm_clamp(int'(r_votes), T);
        w_num = r_y ? 9'(T - w_vc) : 9'(T + w_vc);
    end

    // The draw uses the value the LFSR is about to take, so the decision
    // can be registered straight into the APPLY-cycle pulses.
    assign w_rnd    = tm_lfsr_next(w_lfsr);
    assign w_lhs    = 18'(w_rnd) * C_TWO_T;
    assign w_rhs    = {1'b0, r_num, 8'h00};
    assign w_accept = (w_lhs < w_rhs);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_votes <= '0;
            r_y     <= 1'b0;
            r_num   <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_pred  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_pos  <= 1'b0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_votes <= votes;
                        r_y     <= y;
                        r_state <= CLAMP;
                    end
                end
                CLAMP: begin
                    r_num   <= w_num;
                    r_pred  <= ~r_votes[VOTE_W-1];
                    r_state <= DRAW;
                end
                DRAW: begin
                    r_pos   <= w_accept & r_y;
                    r_neg   <= w_accept & ~r_y;
                    r_done  <= 1'b1;
                    r_state <= APPLY;
                end
                APPLY: begin
                    if ((r_pred != r_y) && (r_err != C_ERR_MAX)) begin
                        r_err <= r_err + ERR_W'(1);
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready          = (r_state == IDLE);
    assign positive_feedback = r_pos;
    assign negative_feedback = r_neg;
    assign done              = r_done;
    assign predicted         = r_pred;
    assign err_cnt           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tm_feedback_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tm_feedback_ctrl
// Purpose  : Self-checking bench for tm_feedback_ctrl (16-bit and 4-bit
//            error-counter instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm_feedback_ctrl;

    localparam int T = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  votes = 3'd0;
    logic        y = 1'b0;

    logic        rdy, pos, neg, dn, pred;
    logic [15:0] err16;
    logic        rdy4, pos4, neg4, dn4, pred4;
    logic [3:0]  err4;

    always #5 clk = ~clk;

    tm_feedback_ctrl #(.VOTE_W(3), .T(T), .LFSR_SEED(8'hA5), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy),
        .votes(votes), .y(y), .positive_feedback(pos), .negative_feedback(neg),
        .done(dn), .predicted(pred), .err_cnt(err16)
    );

    tm_feedback_ctrl #(.VOTE_W(3), .T(T), .LFSR_SEED(8'hA5), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .votes(votes), .y(y), .positive_feedback(pos4), .negative_feedback(neg4),
        .done(dn4), .predicted(pred4), .err_cnt(err4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int cyc = 0;
    int m_lfsr, m_pred, m_err;
    int ready_cyc, pulse_cyc, pred_cyc, err_cyc, pred_val;
    bit m_pos, m_neg;
    int dut_neg_cnt = 0, mdl_neg_cnt = 0, dut_hs_cnt = 0;

    function automatic int lfsr_step(input int s);
        return (s % 2 == 1) ? ((s / 2) ^ 184) : (s / 2);
    endfunction

    initial begin : compare
        int  vs, vc, num, e_err;
        bit  e_ready, e_done, e_pos, e_neg, acc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_lfsr = 165; m_pred = 0; m_err = 0;
                ready_cyc = 0; pulse_cyc = -1; pred_cyc = -1; err_cyc = -1;
            end else begin
                if (cyc == pred_cyc) m_pred = pred_val;
                if (cyc == err_cyc)  m_err  = m_err + 1;
            end
            e_ready = (cyc >= ready_cyc);
            e_done  = (cyc == pulse_cyc);
            e_pos   = e_done && m_pos;
            e_neg   = e_done && m_neg;

            check("in_ready",  rdy,  e_ready);
            check("done",      dn,   e_done);
            check("pos_fb",    pos,  e_pos);
            check("neg_fb",    neg,  e_neg);
            check("predicted", pred, m_pred);
            e_err = (m_err > 65535) ? 65535 : m_err;
            check("err_cnt16", err16, e_err);
            check("in_ready4", rdy4, e_ready);
            check("done4",     dn4,  e_done);
            check("pos_fb4",   pos4, e_pos);
            check("neg_fb4",   neg4, e_neg);
            check("pred4",     pred4, m_pred);
            e_err = (m_err > 15) ? 15 : m_err;
            check("err_cnt4",  err4, e_err);

            if (neg)   dut_neg_cnt++;
            if (e_neg) mdl_neg_cnt++;
            if (rst && in_valid && rdy) dut_hs_cnt++;

            if (rst && in_valid && e_ready) begin
                vs  = int'($signed(votes));
                vc  = (vs > T) ? T : ((vs < -T) ? -T : vs);
                num = y ? (T - vc) : (T + vc);
                m_lfsr = lfsr_step(m_lfsr);
                acc = (m_lfsr * 2 * T) < (num * 256);
                m_pos = acc && y;
                m_neg = acc && !y;
                pred_val  = (vs >= 0) ? 1 : 0;
                ready_cyc = cyc + 4;
                pred_cyc  = cyc + 2;
                pulse_cyc = cyc + 3;
                err_cyc   = (pred_val != int'(y)) ? cyc + 4 : -1;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] v, input logic yy, output logic p, output logic n);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; votes = v; y = yy;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rdy) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("handshake", got, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; votes = 3'($urandom); y = 1'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        p = pos; n = neg;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : stim
        logic p, n;
        int   e0, cnt, h0, d0, m0, dd, md;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", rdy, 1);
        check("rst_err", err16, 0);
        check("rst_pred", pred, 0);
        check("rst_pulses", {pos, neg, dn}, 0);
        @(posedge clk); #1;

        // Reset in the DRAW cycle of an in-flight sample
        in_valid = 1'b1; votes = 3'd0; y = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_pulses", {pos, neg, dn}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", rdy, 1);
        check("midrst_err", err16, 0);
        @(posedge clk); #1;

        // Post-reset draws: rnd = 0xEA, 0x75, 0x82 -> only the middle accepts
        send(3'd0, 1'b0, p, n); check("seq0_neg", n, 0); check("seq0_pos", p, 0);
        send(3'd0, 1'b0, p, n); check("seq1_neg", n, 1);
        send(3'd0, 1'b0, p, n); check("seq2_neg", n, 0);

        // num = 0: never accepts
        e0 = int'(err16); cnt = 0;
        for (int i = 0; i < 50; i++) begin
            send(3'b010, 1'b1, p, n);
            cnt += int'(p);
        end
        check("num0_pos_count", cnt, 0);
        check("num0_err", err16, e0);

        // num = 2T: always accepts, always mispredicts
        e0 = int'(err16); cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send(3'b110, 1'b1, p, n);
            cnt += int'(p);
        end
        check("num4_pos_count", cnt, 20);
        check("num4_pred", pred, 0);
        check("num4_err", err16, e0 + 20);
        check("err4_saturated", err4, 15);

        // Clamp of the most negative vote
        e0 = int'(err16);
        send(3'b100, 1'b0, p, n);
        check("clamp_neg", n, 0);
        check("clamp_pred", pred, 0);
        check("clamp_err", err16, e0);

        // in_valid held high: one handshake per 4 cycles
        h0 = dut_hs_cnt;
        in_valid = 1'b1; votes = 3'b001; y = 1'b1;
        repeat (40) @(posedge clk);
        #1 in_valid = 1'b0;
        check("backpressure_hs", dut_hs_cnt - h0, 10);
        repeat (4) @(posedge clk);
        #1;

        // p = 0.5 statistics
        d0 = dut_neg_cnt; m0 = mdl_neg_cnt;
        for (int i = 0; i < 1000; i++) send(3'd0, 1'b0, p, n);
        dd = dut_neg_cnt - d0; md = mdl_neg_cnt - m0;
        check("stat_vs_model", dd, md);
        check("stat_range", (dd >= 450 && dd <= 550), 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            votes    = 3'($urandom);
            y        = 1'($urandom);
            rst      = ($urandom_range(0, 299) != 0);
            @(posedge clk); #1;
        end
        rst = 1'b1; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
